// File: rtl/apb_initiator.sv
// apb_initiator: turns one valid/ready command into one APB3 transfer and
// returns the completion on a valid/ready response channel. It allows one
// outstanding transfer at a time and has an optional PREADY wait timeout.
module apb_initiator #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  // command channel
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [31:0]               req_wdata,
  // response channel
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  // APB3 initiator port
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  // Last wait-count value allowed before an abort. It wraps to all-ones
  // when TIMEOUT_CYCLES is 0, but the enable flag masks that case.
  localparam logic [31:0] LP_TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam bit          LP_TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t      r_state;
  logic [31:0] r_wait_cnt;
  logic        w_timeout;
  logic        w_unused_addr_lsb;

  // The two low address bits are forced to zero. They are reduced here so
  // that their being unused is visible and intentional.
  assign w_unused_addr_lsb = ^req_addr[1:0];

  // The abort fires only when no PREADY arrives in the final allowed cycle.
  // A PREADY in that same cycle wins.
  assign w_timeout = LP_TMO_EN && !PREADY && (r_wait_cnt == LP_TMO_LAST);

  // Handshake outputs are decoded from the state register. The command side
  // is also held off while reset is asserted.
  assign req_ready = (r_state == S_IDLE) && !HRESET;
  assign rsp_valid = (r_state == S_RESP);

  // Transfer FSM with all APB and response outputs registered.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            PADDR   <= {req_addr[APB_ADDR_WIDTH-1:2], 2'b00};
            PWRITE  <= req_write;
            PWDATA  <= req_write ? req_wdata : '0;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          PENABLE    <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= S_ACCESS;
        end

        S_ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_wait_cnt != '1) begin
            // The counter saturates so it cannot wrap when the timeout is off.
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Testbench for apb_initiator. It applies table vectors with hand-computed
// expectations, then randomized transfers checked against a transfer-level
// model. It also runs a reset-in-ACCESS sequence.
module tb_apb_initiator;

  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 16;

  logic          HCLK;
  logic          HRESET;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_initiator #(
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // One transfer: stimulus fields first, then the expected results.
  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [31:0]   wdata;
    int            waits;      // PREADY=0 cycles before PREADY=1
    logic [31:0]   prdata;
    logic          slverr;
    int            rsp_delay;  // cycles of rsp_ready=0 while rsp_valid=1
    logic [AW-1:0] e_paddr;
    logic [31:0]   e_pwdata;
    int            e_access;   // ACCESS cycles
    logic [31:0]   e_rdata;
    logic          e_err;
    logic          e_tmo;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] addr, input logic write,
                              input logic [31:0] wdata, input int waits,
                              input logic [31:0] prdata, input logic slverr,
                              input int rsp_delay, input logic [AW-1:0] e_paddr,
                              input logic [31:0] e_pwdata, input int e_access,
                              input logic [31:0] e_rdata, input logic e_err,
                              input logic e_tmo);
    vec_t v;
    v.addr = addr; v.write = write; v.wdata = wdata; v.waits = waits;
    v.prdata = prdata; v.slverr = slverr; v.rsp_delay = rsp_delay;
    v.e_paddr = e_paddr; v.e_pwdata = e_pwdata; v.e_access = e_access;
    v.e_rdata = e_rdata; v.e_err = e_err; v.e_tmo = e_tmo;
    return v;
  endfunction

  // Transfer-level reference. A slave that stays busy for TMO or more
  // cycles is cut off after exactly TMO ACCESS cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_paddr  = v.addr & ~AW'(3);
    r.e_pwdata = v.write ? v.wdata : 32'd0;
    if (TMO != 0 && v.waits >= int'(TMO)) begin
      r.e_access = int'(TMO);
      r.e_rdata  = 32'd0;
      r.e_err    = 1'b1;
      r.e_tmo    = 1'b1;
    end else begin
      r.e_access = v.waits + 1;
      r.e_rdata  = v.write ? 32'd0 : v.prdata;
      r.e_err    = v.slverr;
      r.e_tmo    = 1'b0;
    end
    return r;
  endfunction

  // Runs one transfer starting at a negedge in IDLE and ends at the negedge
  // of the first IDLE cycle after the response is consumed.
  task automatic run_txn(input string tag, input vec_t v);
    int          cyc, n_setup, n_access, rsp_cyc, hold;
    logic        done, apb_bad, busy_bad, stable_bad;
    logic [31:0] h_rdata;
    logic        h_err, h_tmo;
    cyc = 1; n_setup = 0; n_access = 0; rsp_cyc = 0; hold = 0;
    done = 0; apb_bad = 0; busy_bad = 0; stable_bad = 0;
    h_rdata = '0; h_err = 0; h_tmo = 0;

    chk({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.write;
    req_wdata = v.wdata;
    @(negedge HCLK);
    // Scramble the command bus so that any missed latching shows up.
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_write = 1'($urandom);
    req_wdata = $urandom;

    while (!done && cyc < 200) begin
      if (req_ready) busy_bad = 1'b1;
      if (rsp_valid && (PSEL || PENABLE)) busy_bad = 1'b1;
      if (PSEL && (PADDR !== v.e_paddr || PWDATA !== v.e_pwdata || PWRITE !== v.write))
        apb_bad = 1'b1;
      if (PSEL && !PENABLE) n_setup++;
      if (PSEL && PENABLE) begin
        PREADY = (n_access >= v.waits);
        n_access++;
      end else begin
        PREADY = 1'($urandom);
      end
      PRDATA  = (PSEL && PENABLE && PREADY) ? v.prdata : $urandom;
      PSLVERR = (PSEL && PENABLE && PREADY) ? v.slverr : 1'($urandom);
      if (rsp_valid) begin
        if (rsp_cyc == 0) begin
          rsp_cyc = cyc; h_rdata = rsp_rdata; h_err = rsp_err; h_tmo = rsp_timeout;
        end else if (rsp_rdata !== h_rdata || rsp_err !== h_err || rsp_timeout !== h_tmo) begin
          stable_bad = 1'b1;
        end
        if (hold < v.rsp_delay) begin
          rsp_ready = 1'b0;
          hold++;
        end else begin
          rsp_ready = 1'b1;
          done = 1'b1;
        end
      end else begin
        rsp_ready = 1'($urandom);
      end
      @(negedge HCLK);
      cyc++;
    end
    rsp_ready = 1'b0;
    PREADY    = 1'b0;

    chk({tag, " completed"},    32'(done),       32'd1);
    chk({tag, " setup_cycles"}, 32'(n_setup),    32'd1);
    chk({tag, " access_cycles"},32'(n_access),   32'(v.e_access));
    chk({tag, " rsp_cycle"},    32'(rsp_cyc),    32'(2 + v.e_access));
    chk({tag, " rsp_rdata"},    h_rdata,         v.e_rdata);
    chk({tag, " rsp_err"},      32'(h_err),      32'(v.e_err));
    chk({tag, " rsp_timeout"},  32'(h_tmo),      32'(v.e_tmo));
    chk({tag, " apb_addr_data"},32'(apb_bad),    32'd0);
    chk({tag, " busy_outputs"}, 32'(busy_bad),   32'd0);
    chk({tag, " rsp_stable"},   32'(stable_bad), 32'd0);
    chk({tag, " post_rsp_valid"},32'(rsp_valid), 32'd0);
    chk({tag, " post_psel"},    32'(PSEL),       32'd0);
    chk({tag, " post_paddr"},   32'(PADDR),      32'(v.e_paddr));
  endtask

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    logic rst_bad;
    logic saw_access;

    HRESET = 1'b1; req_valid = 0; req_addr = '0; req_write = 0; req_wdata = '0;
    rsp_ready = 0; PRDATA = '0; PREADY = 0; PSLVERR = 0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst PSEL",        32'(PSEL),        32'd0);
    chk("rst PENABLE",     32'(PENABLE),     32'd0);
    chk("rst PWRITE",      32'(PWRITE),      32'd0);
    chk("rst PADDR",       32'(PADDR),       32'd0);
    chk("rst PWDATA",      PWDATA,           32'd0);
    chk("rst rsp_valid",   32'(rsp_valid),   32'd0);
    chk("rst rsp_err",     32'(rsp_err),     32'd0);
    chk("rst rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst rsp_rdata",   rsp_rdata,        32'd0);
    chk("rst req_ready",   32'(req_ready),   32'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst release req_ready", 32'(req_ready), 32'd1);

    //            addr    wr  wdata         wt    prdata        err dly  paddr   pwdata        acc rdata         err tmo
    tbl[0] = mk(12'h008, 1, 32'h0000_0100,    0, 32'hFFFF_FFFF, 0, 0, 12'h008, 32'h0000_0100, 1, 32'h0,         0, 0);
    tbl[1] = mk(12'h000, 0, 32'h1111_2222,    3, 32'hDEAD_BEEF, 0, 0, 12'h000, 32'h0,         4, 32'hDEAD_BEEF, 0, 0);
    tbl[2] = mk(12'h006, 0, 32'h0,            0, 32'h1234_5678, 1, 0, 12'h004, 32'h0,         1, 32'h1234_5678, 1, 0);
    tbl[3] = mk(12'h010, 1, 32'hA5A5_A5A5, 1000, 32'h5555_AAAA, 0, 0, 12'h010, 32'hA5A5_A5A5,16, 32'h0,         1, 1);
    tbl[4] = mk(12'hFFC, 0, 32'h0,            2, 32'hCAFE_F00D, 0, 5, 12'hFFC, 32'h0,         3, 32'hCAFE_F00D, 0, 0);
    tbl[5] = mk(12'h123, 0, 32'h0,           15, 32'h0BAD_CAFE, 0, 1, 12'h120, 32'h0,        16, 32'h0BAD_CAFE, 0, 0);
    tbl[6] = mk(12'hABD, 1, 32'h0F0F_0F0F,    0, 32'h7777_7777, 1, 2, 12'hABC, 32'h0F0F_0F0F, 1, 32'h0,         1, 0);
    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i]);
    end

    // Reset during ACCESS: the transfer is dropped and produces no response.
    req_valid = 1'b1; req_addr = 12'h040; req_write = 1'b0; req_wdata = '0;
    @(negedge HCLK);
    req_valid = 1'b0;
    saw_access = 1'b0;
    for (int c = 0; c < 4 && !saw_access; c++) begin
      PREADY = 1'b0;
      if (PSEL && PENABLE) saw_access = 1'b1;
      else @(negedge HCLK);
    end
    chk("midrst reached_access", 32'(saw_access), 32'd1);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("midrst PSEL",      32'(PSEL),      32'd0);
    chk("midrst PENABLE",   32'(PENABLE),   32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("midrst release req_ready", 32'(req_ready), 32'd1);
    rst_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); rsp_ready = 1'($urandom);
      if (rsp_valid || PSEL || !req_ready) rst_bad = 1'b1;
      @(negedge HCLK);
    end
    rsp_ready = 1'b0; PREADY = 1'b0;
    chk("midrst no_response", 32'(rst_bad), 32'd0);
    run_txn("post_rst", model(mk(12'h044, 1, 32'h600D_0001, 1, 32'h0, 0, 0, '0, '0, 0, '0, 0, 0)));

    // Randomized transfers, some long enough to reach the timeout.
    for (int i = 0; i < 40; i++) begin
      v = mk(AW'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 20)),
             $urandom, 1'($urandom), int'($urandom_range(0, 3)),
             '0, '0, 0, '0, 0, 0);
      run_txn($sformatf("rnd%0d", i), model(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
